datamem_dumper: RTL and testbench
=================================

Name: datamem_dumper

Overview:
- Read-side initiator for the data memory. On a start pulse it walks data-memory addresses 0..N_WORDS-1 by driving Rd/Addr, and captures each 16-bit word.
- Each word is streamed MSB byte first to the UART transmitter over a valid/ready byte handshake.
- Used by the debug unit to dump data memory contents to the host after program execution.

Parameters:
- NBITS_O, 11, memory address width.
- NBITS_D, 16, memory data width; must be 2*NBITS_B.
- NBITS_B, 8, byte width toward the transmitter.
- N_WORDS, 10, number of words dumped; legal range 1..2^NBITS_O.

Ports:
- i_clk  in  1  system clock, all logic on rising edge.
- i_reset  in  1  synchronous, active-high reset.
- i_start  in  1  one-cycle request to begin a dump; sampled only in IDLE.
- i_MemData  in  NBITS_D  read data returned by data memory for o_Addr.
- o_Rd  out  1  memory read strobe.
- o_Wr  out  1  memory write strobe; constant 0.
- o_Addr  out  NBITS_O  memory address, registered.
- o_TxData  out  NBITS_B  byte offered to the transmitter.
- o_TxValid  out  1  o_TxData is valid.
- i_TxReady  in  1  transmitter accepts the byte this cycle.
- o_Busy  out  1  high in every state except IDLE.
- o_Done  out  1  one-cycle pulse when the last byte has been accepted.

Behaviour:
- Reset (i_clk edge with i_reset=1):
  - state=IDLE, address counter=0, word register=0.
  - All outputs 0.
  - Reset wins over every other input. Mid-operation it aborts immediately: no further bytes and no o_Done.
- All outputs are registered or decoded from the registered state. There are no combinational paths from inputs to outputs.
- States:
  - IDLE: outputs 0. i_start=1 moves to ADDR with counter=0.
  - ADDR: o_Rd=1, o_Addr=counter. Unconditionally goes to READ next cycle.
  - READ: o_Rd=1, o_Addr held. The word register loads i_MemData at the end of this cycle, giving the memory one full cycle to settle. Goes to SEND_HI.
  - SEND_HI: o_TxValid=1, o_TxData=word[NBITS_D-1:NBITS_B]. Goes to SEND_LO on the edge where o_TxValid&&i_TxReady.
  - SEND_LO: o_TxValid=1, o_TxData=word[NBITS_B-1:0]. Goes to NEXT on the handshake edge.
  - NEXT: o_TxValid=0. If counter==N_WORDS-1, go to DONE. Otherwise counter+1 and go to ADDR.
  - DONE: o_Done=1 for exactly one cycle, then IDLE.
- o_Rd is 0 in all states except ADDR and READ.
- Handshake rules:
  - A byte transfers only on a cycle with o_TxValid=1 and i_TxReady=1.
  - While o_TxValid=1 and i_TxReady=0, o_TxData is stable.
  - o_TxValid never drops without a transfer.
  - i_TxReady is ignored when o_TxValid=0.
- Timing:
  - With i_TxReady held at 1, each word takes 5 cycles (ADDR, READ, HI, LO, NEXT).
  - Start sampled at edge 0 means ADDR in cycle 1.
  - Word k occupies cycles 5k+1..5k+5.
  - o_Done is in cycle 5*N_WORDS+1.
  - Each cycle of i_TxReady=0 during SEND_HI/SEND_LO adds one cycle.
- Boundaries:
  - i_start while o_Busy=1 is ignored.
  - i_start on the same cycle as o_Done is ignored, because the block is not yet in IDLE.
  - Counter terminal compare uses NBITS_O+1 bits, so N_WORDS=2^NBITS_O ends at the all-ones address without wrap.
  - The counter never wraps during a dump.
  - N_WORDS=1 dumps address 0 only.

Test Plan:
- Memory model preloaded with word n at address n (n=0..9), N_WORDS=10, i_TxReady=1, start pulse -> 20 bytes 00 00 00 01 ... 00 09 in order, o_Done in cycle 51, o_Busy high cycles 1..51, o_Wr always 0.
- Address 3 holds 0xA5C3, N_WORDS=4 -> fourth word emitted as A5 then C3; o_Addr=3 with o_Rd=1 for exactly 2 cycles.
- i_TxReady=0 for 3 cycles while SEND_HI of word 2 is offered -> o_TxData=0x00 and o_TxValid=1 stable for 4 cycles, single transfer; o_Done delayed to cycle 54.
- Extra i_start pulses in cycles 7 and 51 -> ignored; exactly 20 bytes and one o_Done; a new start in cycle 53 restarts at o_Addr=0.
- i_reset asserted during SEND_LO of word 4 -> next cycle all outputs 0, state IDLE, no o_Done; a subsequent start dumps from address 0 again.
- N_WORDS=1, i_TxReady toggling 0/1 each cycle -> exactly bytes 00 00, o_Done once, then idle.

Source files
------------

// File: rtl/datamem_dumper.sv
`default_nettype none
// ============================================================================
// Module      : datamem_dumper
// Description : Walks data memory addresses 0..N_WORDS-1 and streams each
//               word to the UART transmitter, MSB byte first.
// Revision    : 1.0 - initial release
// ============================================================================
module datamem_dumper #(
    parameter int NBITS_O = 11,
    parameter int NBITS_D = 16,
    parameter int NBITS_B = 8,
    parameter int N_WORDS = 10
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [NBITS_D-1:0] i_MemData,
    output logic               o_Rd,
    output logic               o_Wr,
    output logic [NBITS_O-1:0] o_Addr,
    output logic [NBITS_B-1:0] o_TxData,
    output logic               o_TxValid,
    input  logic               i_TxReady,
    output logic               o_Busy,
    output logic               o_Done
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ADDR    = 3'd1,
        S_READ    = 3'd2,
        S_SEND_HI = 3'd3,
        S_SEND_LO = 3'd4,
        S_NEXT    = 3'd5,
        S_DONE    = 3'd6
    } state_t;

    // One extra bit so N_WORDS = 2^NBITS_O terminates at the all-ones address.
    localparam logic [NBITS_O:0] c_last_idx = (NBITS_O + 1)'(N_WORDS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [NBITS_O-1:0]   r_addr;
    logic [NBITS_D-1:0]   r_word;
    logic                 w_is_last;

    assign w_is_last = ({1'b0, r_addr} == c_last_idx);

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_addr  <= '0;
            r_word  <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: if (i_start) r_addr <= '0;
                S_READ: r_word <= i_MemData;
                S_NEXT: if (!w_is_last) r_addr <= r_addr + 1'b1;
                S_DONE: r_addr <= '0;
                default: ;
            endcase
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (i_start) w_next = S_ADDR;
            S_ADDR:    w_next = S_READ;
            S_READ:    w_next = S_SEND_HI;
            S_SEND_HI: if (i_TxReady) w_next = S_SEND_LO;
            S_SEND_LO: if (i_TxReady) w_next = S_NEXT;
            S_NEXT:    w_next = w_is_last ? S_DONE : S_ADDR;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // Outputs are pure decodes of registered state, address and word.
    always_comb begin
        o_TxData = '0;
        case (r_state)
            S_SEND_HI: o_TxData = r_word[NBITS_D-1:NBITS_B];
            S_SEND_LO: o_TxData = r_word[NBITS_B-1:0];
            default:   o_TxData = '0;
        endcase
    end

    assign o_Rd      = (r_state == S_ADDR) || (r_state == S_READ);
    assign o_Wr      = 1'b0;
    assign o_Addr    = r_addr;
    assign o_TxValid = (r_state == S_SEND_HI) || (r_state == S_SEND_LO);
    assign o_Busy    = (r_state != S_IDLE);
    assign o_Done    = (r_state == S_DONE);

endmodule
`default_nettype wire

// File: tb/tb_datamem_dumper.sv
`default_nettype none
// ============================================================================
// Module      : tb_datamem_dumper
// Description : Self-checking bench for datamem_dumper (N_WORDS = 10, 4, 1).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_datamem_dumper;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_ready, a_rd, a_wr, a_txv, a_busy, a_done;
    logic [10:0] a_addr;
    logic [15:0] a_mdata;
    logic [7:0]  a_txd;
    logic        b_start, b_ready, b_rd, b_wr, b_txv, b_busy, b_done;
    logic [10:0] b_addr;
    logic [15:0] b_mdata;
    logic [7:0]  b_txd;
    logic        c_start, c_ready, c_rd, c_wr, c_txv, c_busy, c_done;
    logic [10:0] c_addr;
    logic [15:0] c_mdata;
    logic [7:0]  c_txd;

    logic [15:0] mem_a [16];
    logic [15:0] mem_b [16];
    logic [15:0] mem_c [16];

    assign a_mdata = mem_a[a_addr[3:0]];
    assign b_mdata = mem_b[b_addr[3:0]];
    assign c_mdata = mem_c[c_addr[3:0]];

    datamem_dumper #(.NBITS_O(11), .NBITS_D(16), .NBITS_B(8), .N_WORDS(10)) u_a (
        .i_clk(clk), .i_reset(rst), .i_start(a_start), .i_MemData(a_mdata),
        .o_Rd(a_rd), .o_Wr(a_wr), .o_Addr(a_addr), .o_TxData(a_txd),
        .o_TxValid(a_txv), .i_TxReady(a_ready), .o_Busy(a_busy), .o_Done(a_done));

    datamem_dumper #(.NBITS_O(11), .NBITS_D(16), .NBITS_B(8), .N_WORDS(1)) u_b (
        .i_clk(clk), .i_reset(rst), .i_start(b_start), .i_MemData(b_mdata),
        .o_Rd(b_rd), .o_Wr(b_wr), .o_Addr(b_addr), .o_TxData(b_txd),
        .o_TxValid(b_txv), .i_TxReady(b_ready), .o_Busy(b_busy), .o_Done(b_done));

    datamem_dumper #(.NBITS_O(11), .NBITS_D(16), .NBITS_B(8), .N_WORDS(4)) u_c (
        .i_clk(clk), .i_reset(rst), .i_start(c_start), .i_MemData(c_mdata),
        .o_Rd(c_rd), .o_Wr(c_wr), .o_Addr(c_addr), .o_TxData(c_txd),
        .o_TxValid(c_txv), .i_TxReady(c_ready), .o_Busy(c_busy), .o_Done(c_done));

    logic [7:0] qa[$];
    logic [7:0] qb[$];
    logic [7:0] qc[$];
    int n_tests = 0;
    int n_fail  = 0;
    int a_done_cnt = 0, b_done_cnt = 0, c_done_cnt = 0;
    int wr_bad = 0, c_addr3_cnt = 0;
    logic mon_en = 1'b0;
    logic [7:0] mon_exp;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        n_tests++;
        if (act !== exp_v) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp_v);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Byte scoreboard and event counters for all three instances.
    always @(negedge clk) begin
        if (mon_en) begin
            if (a_txv && a_ready) begin
                if (qa.size() == 0) check("a_unexpected_byte", {24'd0, a_txd}, 32'hFFFF_FFFF);
                else begin mon_exp = qa.pop_front(); check("a_byte", {24'd0, a_txd}, {24'd0, mon_exp}); end
            end
            if (b_txv && b_ready) begin
                if (qb.size() == 0) check("b_unexpected_byte", {24'd0, b_txd}, 32'hFFFF_FFFF);
                else begin mon_exp = qb.pop_front(); check("b_byte", {24'd0, b_txd}, {24'd0, mon_exp}); end
            end
            if (c_txv && c_ready) begin
                if (qc.size() == 0) check("c_unexpected_byte", {24'd0, c_txd}, 32'hFFFF_FFFF);
                else begin mon_exp = qc.pop_front(); check("c_byte", {24'd0, c_txd}, {24'd0, mon_exp}); end
            end
            if (a_done === 1'b1) a_done_cnt++;
            if (b_done === 1'b1) b_done_cnt++;
            if (c_done === 1'b1) c_done_cnt++;
            if (c_rd === 1'b1 && c_addr == 11'd3) c_addr3_cnt++;
            if (a_wr !== 1'b0 || b_wr !== 1'b0 || c_wr !== 1'b0) wr_bad++;
        end
    end

    typedef struct packed {
        logic        start;
        logic        ready;
        logic        rd;
        logic [10:0] addr;
        logic        valid;
        logic [7:0]  data;
        logic        busy;
        logic        done;
    } vec_t;

    vec_t vt [11];

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Cycle-by-cycle expectations for the first two words of dump 1.
        vt[0]  = '{1'b1, 1'b1, 1'b0, 11'd0, 1'b0, 8'h00, 1'b0, 1'b0};
        vt[1]  = '{1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[2]  = '{1'b0, 1'b1, 1'b1, 11'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[3]  = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[4]  = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[5]  = '{1'b0, 1'b1, 1'b0, 11'd0, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b1, 1'b1, 11'd1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[7]  = '{1'b1, 1'b1, 1'b1, 11'd1, 1'b0, 8'h00, 1'b1, 1'b0};
        vt[8]  = '{1'b0, 1'b1, 1'b0, 11'd1, 1'b1, 8'h00, 1'b1, 1'b0};
        vt[9]  = '{1'b0, 1'b1, 1'b0, 11'd1, 1'b1, 8'h01, 1'b1, 1'b0};
        vt[10] = '{1'b0, 1'b1, 1'b0, 11'd1, 1'b0, 8'h00, 1'b1, 1'b0};

        for (int n = 0; n < 16; n++) begin
            mem_a[n] = 16'(n);
            mem_b[n] = 16'hFFFF;
            mem_c[n] = 16'(n);
        end
        mem_b[0] = 16'h0000;
        mem_c[3] = 16'hA5C3;

        rst = 1'b1;
        a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
        a_ready = 1'b1; b_ready = 1'b0; c_ready = 1'b1;
        tick();
        tick();
        @(negedge clk);
        check("rst_rd",    {31'd0, a_rd},    32'd0);
        check("rst_addr",  {21'd0, a_addr},  32'd0);
        check("rst_valid", {31'd0, a_txv},   32'd0);
        check("rst_data",  {24'd0, a_txd},   32'd0);
        check("rst_busy",  {31'd0, a_busy},  32'd0);
        check("rst_done",  {31'd0, a_done},  32'd0);
        mon_en = 1'b1;
        tick();
        rst = 1'b0;
        tick();

        // Dump 1: table-driven first cycles, extra start in cycle 7.
        for (int i = 0; i < 11; i++) begin
            a_start = vt[i].start;
            a_ready = vt[i].ready;
            if (vt[i].start && !vt[i].busy)
                for (int n = 0; n < 10; n++) begin qa.push_back(mem_a[n][15:8]); qa.push_back(mem_a[n][7:0]); end
            @(negedge clk);
            check($sformatf("vec%0d_rd", i),    {31'd0, a_rd},   {31'd0, vt[i].rd});
            if (vt[i].rd || !vt[i].busy)
                check($sformatf("vec%0d_addr", i), {21'd0, a_addr}, {21'd0, vt[i].addr});
            check($sformatf("vec%0d_valid", i), {31'd0, a_txv},  {31'd0, vt[i].valid});
            check($sformatf("vec%0d_data", i),  {24'd0, a_txd},  {24'd0, vt[i].data});
            check($sformatf("vec%0d_busy", i),  {31'd0, a_busy}, {31'd0, vt[i].busy});
            check($sformatf("vec%0d_done", i),  {31'd0, a_done}, {31'd0, vt[i].done});
            tick();
        end
        // Remaining words; start coincident with o_Done in cycle 51.
        for (int c = 11; c <= 52; c++) begin
            a_start = (c == 51);
            a_ready = 1'b1;
            @(negedge clk);
            check($sformatf("d1_busy_c%0d", c), {31'd0, a_busy}, {31'd0, (c <= 51)});
            check($sformatf("d1_done_c%0d", c), {31'd0, a_done}, {31'd0, (c == 51)});
            tick();
        end

        // Dump 2 from cycle 53, aborted by reset during SEND_LO of word 4.
        a_start = 1'b1;
        for (int n = 0; n < 10; n++) begin qa.push_back(mem_a[n][15:8]); qa.push_back(mem_a[n][7:0]); end
        @(negedge clk);
        check("d1_done_once", a_done_cnt, 1);
        check("d1_queue_empty_before_d2", qa.size(), 20);
        check("c53_busy", {31'd0, a_busy}, 32'd0);
        tick();
        a_start = 1'b0;
        @(negedge clk);
        check("d2_restart_rd",   {31'd0, a_rd},   32'd1);
        check("d2_restart_addr", {21'd0, a_addr}, 32'd0);
        for (int c = 54; c < 77; c++) tick();
        rst = 1'b1;
        a_ready = 1'b0;
        check("d2_bytes_before_reset", qa.size(), 11);
        qa.delete();
        @(negedge clk);
        check("d2_lo_valid", {31'd0, a_txv}, 32'd1);
        check("d2_lo_data",  {24'd0, a_txd}, 32'h04);
        tick();
        rst = 1'b0;
        a_ready = 1'b1;
        @(negedge clk);
        check("abort_rd",    {31'd0, a_rd},   32'd0);
        check("abort_addr",  {21'd0, a_addr}, 32'd0);
        check("abort_valid", {31'd0, a_txv},  32'd0);
        check("abort_data",  {24'd0, a_txd},  32'd0);
        check("abort_busy",  {31'd0, a_busy}, 32'd0);
        check("abort_done",  {31'd0, a_done}, 32'd0);
        tick();
        @(negedge clk);
        check("abort_idle_busy", {31'd0, a_busy}, 32'd0);
        check("abort_no_done", a_done_cnt, 1);
        tick();

        // Dump 3 from cycle 80 with a 3-cycle stall on word 2 high byte.
        a_start = 1'b1;
        for (int n = 0; n < 10; n++) begin qa.push_back(mem_a[n][15:8]); qa.push_back(mem_a[n][7:0]); end
        tick();
        a_start = 1'b0;
        for (int c = 81; c <= 135; c++) begin
            a_ready = !(c >= 93 && c <= 95);
            @(negedge clk);
            if (c >= 93 && c <= 96) begin
                check($sformatf("stall_valid_c%0d", c), {31'd0, a_txv}, 32'd1);
                check($sformatf("stall_data_c%0d", c),  {24'd0, a_txd}, 32'h00);
            end
            if (c == 133) check("stall_done_c133", {31'd0, a_done}, 32'd0);
            if (c == 134) check("stall_done_c134", {31'd0, a_done}, 32'd1);
            if (c == 135) check("stall_busy_c135", {31'd0, a_busy}, 32'd0);
            tick();
        end
        check("d3_all_bytes", qa.size(), 0);
        check("a_done_total", a_done_cnt, 2);

        // N_WORDS = 4: address 3 holds 0xA5C3.
        c_start = 1'b1;
        for (int n = 0; n < 4; n++) begin qc.push_back(mem_c[n][15:8]); qc.push_back(mem_c[n][7:0]); end
        tick();
        c_start = 1'b0;
        for (int c = 0; c < 25; c++) tick();
        @(negedge clk);
        check("c_all_bytes", qc.size(), 0);
        check("c_done_once", c_done_cnt, 1);
        check("c_addr3_rd_cycles", c_addr3_cnt, 2);
        check("c_idle", {31'd0, c_busy}, 32'd0);
        tick();

        // N_WORDS = 1 with ready toggling every cycle.
        b_start = 1'b1;
        b_ready = 1'b0;
        qb.push_back(mem_b[0][15:8]);
        qb.push_back(mem_b[0][7:0]);
        tick();
        b_start = 1'b0;
        for (int c = 0; c < 20; c++) begin
            b_ready = ~b_ready;
            tick();
        end
        @(negedge clk);
        check("b_all_bytes", qb.size(), 0);
        check("b_done_once", b_done_cnt, 1);
        check("b_idle", {31'd0, b_busy}, 32'd0);
        check("wr_never_high", wr_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
